// File: rtl/matmul_sequencer.sv
// matmul_sequencer: drives the select/enable lines of an NxN matrix-multiply
// datapath through operand load, MAC accumulation and result writeback.
module matmul_sequencer #(
  parameter int N     = 3,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_en,
  output logic             load_mat,
  output logic [SEL_W-1:0] load_sel,
  output logic [SEL_W-1:0] mux_a_sel,
  output logic [SEL_W-1:0] mux_b_sel,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             res_ld,
  output logic [SEL_W-1:0] res_sel,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, all outputs low
  // LOAD  | accepting A elements then B elements from the host
  // MAC   | accumulating one dot-product term per cycle
  // WB    | writing the finished accumulator into the result bank
  // DONE  | one-cycle completion pulse

  localparam int NN   = N * N;
  localparam int LD_W = (2 * NN > 1) ? $clog2(2 * NN) : 1;

  localparam logic [LD_W-1:0]  LD_LAST = LD_W'(2 * NN - 1);
  localparam logic [LD_W-1:0]  LD_NN   = LD_W'(NN);
  localparam logic [LD_W-1:0]  LD_ONE  = LD_W'(1);
  localparam logic [SEL_W-1:0] N_SEL   = SEL_W'(N);
  localparam logic [SEL_W-1:0] N_LAST  = SEL_W'(N - 1);
  localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);

  if (NN > (2 ** SEL_W)) begin : g_size_check
    $error("matmul_sequencer: N*N exceeds the range of SEL_W-bit selects");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_WB   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [SEL_W-1:0] i_q, i_d;
  logic [SEL_W-1:0] j_q, j_d;
  logic [SEL_W-1:0] k_q, k_d;
  logic [LD_W-1:0]  ld_idx;
  logic             xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ld_cnt_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  assign xfer = in_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (ld_cnt_q == LD_LAST) begin
            state_d  = ST_MAC;
            ld_cnt_d = '0;
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + LD_ONE;
          end
        end
      end
      ST_MAC: begin
        if (k_q == N_LAST) begin
          state_d = ST_WB;
          k_d     = '0;
        end else begin
          k_d = k_q + SEL_ONE;
        end
      end
      ST_WB: begin
        k_d = '0;
        if ((i_q == N_LAST) && (j_q == N_LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MAC;
          if (j_q == N_LAST) begin
            j_d = '0;
            i_d = i_q + SEL_ONE;
          end else begin
            j_d = j_q + SEL_ONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Second half of the load stream addresses the B bank from index 0 again.
  assign ld_idx = (ld_cnt_q >= LD_NN) ? (ld_cnt_q - LD_NN) : ld_cnt_q;

  always_comb begin
    in_ready  = 1'b0;
    load_en   = 1'b0;
    load_mat  = 1'b0;
    load_sel  = '0;
    mux_a_sel = '0;
    mux_b_sel = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    res_ld    = 1'b0;
    res_sel   = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        in_ready = 1'b1;
        load_en  = in_valid;
        load_mat = (ld_cnt_q >= LD_NN);
        load_sel = SEL_W'(ld_idx);
        busy     = 1'b1;
      end
      ST_MAC: begin
        mac_en    = 1'b1;
        mac_clr   = (k_q == '0);
        mux_a_sel = i_q * N_SEL + k_q;
        mux_b_sel = k_q * N_SEL + j_q;
        busy      = 1'b1;
      end
      ST_WB: begin
        res_ld  = 1'b1;
        res_sel = i_q * N_SEL + j_q;
        busy    = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: vector table for run timing plus a result scoreboard
// fed by a behavioural operand-bank/MAC datapath driven from the DUT selects.
module tb_matmul_sequencer;
  localparam int N     = 3;
  localparam int SEL_W = 4;
  localparam int NN    = N * N;

  logic clk = 1'b0;
  logic reset, start, in_valid;
  logic in_ready, load_en, load_mat, mac_en, mac_clr, res_ld, busy, done;
  logic [SEL_W-1:0] load_sel, mux_a_sel, mux_b_sel, res_sel;

  matmul_sequencer #(.N(N), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .load_en(load_en), .load_mat(load_mat),
    .load_sel(load_sel), .mux_a_sel(mux_a_sel), .mux_b_sel(mux_b_sel),
    .mac_en(mac_en), .mac_clr(mac_clr), .res_ld(res_ld), .res_sel(res_sel),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [23:0] exp; } vec_t;
  typedef struct { int cyc; logic [3:0] idx; int val; } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   ncmp = 0, nbad = 0;
  int   ma[NN], mb[NN];
  int   bank_a[16], bank_b[16];
  int   acc, xfer;

  function automatic logic [23:0] obs();
    return {in_ready, load_en, load_mat, load_sel, mac_en, mac_clr,
            mux_a_sel, mux_b_sel, res_ld, res_sel, busy, done};
  endfunction

  function automatic vec_t vec(input int c, input logic ir, le, lm, input logic [3:0] ls,
                               input logic me, mc, input logic [3:0] xa, xb,
                               input logic rl, input logic [3:0] rs, input logic bz, dn);
    vec_t v;
    v.cyc = c;
    v.exp = {ir, le, lm, ls, me, mc, xa, xb, rl, rs, bz, dn};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Behavioural datapath: operand banks, registered MAC, result scoreboard.
  task automatic sample(input int r);
    int v, p;
    if (res_ld) begin
      if (sb.size() == 0) chk("res_ld_unexpected", 1, 0);
      else begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("res_pos@%0d", r), {r, res_sel}, {e.cyc, e.idx});
        chk($sformatf("res_val[%0d]", e.idx), acc, e.val);
      end
    end
    if (load_en) begin
      v = (xfer < NN) ? ma[xfer] : ((xfer < 2 * NN) ? mb[xfer - NN] : -7);
      if (load_mat) bank_b[load_sel] = v;
      else bank_a[load_sel] = v;
      xfer++;
    end
    if (mac_en) begin
      p = bank_a[mux_a_sel] * bank_b[mux_b_sel];
      acc = mac_clr ? p : acc + p;
    end
  endtask

  // vmode 0: in_valid always high, 1: toggling. smode 0: pulse, 1: extra pulses, 2: held.
  task automatic do_run(input int vmode, input int smode, input int rst_at,
                        input bit tbl_on, input int dmode);
    int load_len, done_exp, last_r, done_seen, s;
    load_len  = (vmode == 1) ? 35 : 18;
    done_exp  = 1 + load_len + NN * (N + 1);
    last_r    = (rst_at >= 0) ? rst_at + 1 : done_exp + 2;
    done_seen = -1;
    for (int e = 0; e < NN; e++) begin
      ma[e] = (dmode == 0) ? ((e / N == e % N) ? 1 : 0) :
              (dmode == 1) ? 2 : int'($urandom_range(0, 15));
      mb[e] = (dmode == 0) ? e + 1 :
              (dmode == 1) ? 2 : int'($urandom_range(0, 15));
    end
    for (int e = 0; e < 16; e++) begin
      bank_a[e] = -1000;
      bank_b[e] = -1000;
    end
    acc = 0;
    xfer = 0;
    for (int e = 0; e < NN; e++) begin
      s = 0;
      for (int k = 0; k < N; k++) s += ma[(e / N) * N + k] * mb[k * N + (e % N)];
      sb.push_back('{cyc: 1 + load_len + 3 + 4 * e, idx: 4'(e), val: s});
    end
    for (int r = 0; r <= last_r; r++) begin
      @(posedge clk); #1;
      start    = (r == 0) || (smode == 2) || (smode == 1 && (r == 5 || r == 25));
      in_valid = (vmode == 0) ? 1'b1 : ((r == 0) || (r % 2 == 1));
      reset    = (r == rst_at);
      @(negedge clk);
      sample(r);
      if (done && done_seen < 0) done_seen = r;
      if (tbl_on)
        foreach (tbl[t])
          if (tbl[t].cyc == r) chk($sformatf("vec@%0d", r), obs(), tbl[t].exp);
      if (vmode == 1 && r <= 40)
        chk($sformatf("load_en_toggle@%0d", r), load_en, (r >= 1 && r <= 35 && r % 2 == 1));
      if (smode == 2 && r == done_exp + 1) chk("held_start_idle_busy", busy, 0);
      if (smode == 2 && r == done_exp + 2) chk("held_start_reload", {busy, in_ready}, 2'b11);
      if (rst_at >= 0 && r == rst_at + 1) chk("reset_mid_run_outputs", obs(), 0);
    end
    if (rst_at < 0) begin
      chk("done_cycle", done_seen, done_exp);
      chk("res_ld_count_left", sb.size(), 0);
    end else begin
      sb.delete();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    tbl.push_back(vec(0,  0,0,0,4'd0, 0,0,4'd0,4'd0, 0,4'd0, 0,0));
    tbl.push_back(vec(1,  1,1,0,4'd0, 0,0,4'd0,4'd0, 0,4'd0, 1,0));
    tbl.push_back(vec(9,  1,1,0,4'd8, 0,0,4'd0,4'd0, 0,4'd0, 1,0));
    tbl.push_back(vec(10, 1,1,1,4'd0, 0,0,4'd0,4'd0, 0,4'd0, 1,0));
    tbl.push_back(vec(18, 1,1,1,4'd8, 0,0,4'd0,4'd0, 0,4'd0, 1,0));
    tbl.push_back(vec(19, 0,0,0,4'd0, 1,1,4'd0,4'd0, 0,4'd0, 1,0));
    tbl.push_back(vec(20, 0,0,0,4'd0, 1,0,4'd1,4'd3, 0,4'd0, 1,0));
    tbl.push_back(vec(21, 0,0,0,4'd0, 1,0,4'd2,4'd6, 0,4'd0, 1,0));
    tbl.push_back(vec(22, 0,0,0,4'd0, 0,0,4'd0,4'd0, 1,4'd0, 1,0));
    tbl.push_back(vec(23, 0,0,0,4'd0, 1,1,4'd0,4'd1, 0,4'd0, 1,0));
    tbl.push_back(vec(39, 0,0,0,4'd0, 1,1,4'd3,4'd2, 0,4'd0, 1,0));
    tbl.push_back(vec(40, 0,0,0,4'd0, 1,0,4'd4,4'd5, 0,4'd0, 1,0));
    tbl.push_back(vec(41, 0,0,0,4'd0, 1,0,4'd5,4'd8, 0,4'd0, 1,0));
    tbl.push_back(vec(42, 0,0,0,4'd0, 0,0,4'd0,4'd0, 1,4'd5, 1,0));
    tbl.push_back(vec(54, 0,0,0,4'd0, 0,0,4'd0,4'd0, 1,4'd8, 1,0));
    tbl.push_back(vec(55, 0,0,0,4'd0, 0,0,4'd0,4'd0, 0,4'd0, 0,1));
    tbl.push_back(vec(56, 0,0,0,4'd0, 0,0,4'd0,4'd0, 0,4'd0, 0,0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", obs(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignores_in_valid", {busy, in_ready, load_en}, 3'b000);
      @(posedge clk); #1;
    end

    do_run(0, 0, -1, 1'b1, 0);
    do_run(0, 1, -1, 1'b1, 1);
    do_run(1, 0, -1, 1'b0, 0);
    do_run(0, 0, 30, 1'b1, 2);
    do_run(0, 0, -1, 1'b1, 2);
    do_run(0, 2, -1, 1'b1, 1);

    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("final_reset_outputs", obs(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
